// File: rtl/pd_rd_arbiter.sv
// pd_rd_arbiter: shares the PD-FIFO read port between the cell read engine (CR)
// and the head-drop engine (HD). One requester at a time owns the port: the grant
// pulses a one-hot pop (o_pd_ptr_ack) and ownership holds until the owner's done
// pulse, or until the hold watchdog forces a release.
//
// Optional feature macro: PD_ARB_STATS_EN adds grant/watchdog statistics outputs.
//
// Ports:
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_cr_req/i_cr_qid/i_cr_done     CR request, requested queue, release pulse
//   o_cr_gnt/o_cr_own               CR grant pulse, CR owns the port
//   i_hd_req/i_hd_qid/i_hd_done     HD request, requested queue, release pulse
//   o_hd_gnt/o_hd_own               HD grant pulse, HD owns the port
//   i_pd_ptr_rdy                    per-queue PD available
//   o_pd_ptr_ack                    one-hot PD pop pulse, coincident with grant
//   o_wdog_err                      1-cycle pulse on watchdog-forced release
//   o_cr_gnt_cnt/o_hd_gnt_cnt/o_wdog_cnt  event counters (PD_ARB_STATS_EN only)
module pd_rd_arbiter #(
  parameter int unsigned NUM_Q      = 4,
  parameter int unsigned QW         = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned HOLD_MAX   = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cr_req,
  input  logic [QW-1:0]    i_cr_qid,
  input  logic             i_cr_done,
  output logic             o_cr_gnt,
  output logic             o_cr_own,
  input  logic             i_hd_req,
  input  logic [QW-1:0]    i_hd_qid,
  input  logic             i_hd_done,
  output logic             o_hd_gnt,
  output logic             o_hd_own,
  input  logic [NUM_Q-1:0] i_pd_ptr_rdy,
  output logic [NUM_Q-1:0] o_pd_ptr_ack,
  output logic             o_wdog_err
`ifdef PD_ARB_STATS_EN
  ,
  output logic [31:0]      o_cr_gnt_cnt,
  output logic [31:0]      o_hd_gnt_cnt,
  output logic [15:0]      o_wdog_cnt
`endif
);

  localparam int unsigned HW = 8;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN_CR, ST_OWN_HD} state_t;

  state_t           r_state;
  logic             r_cr_gnt;
  logic             r_cr_own;
  logic             r_hd_gnt;
  logic             r_hd_own;
  logic [NUM_Q-1:0] r_ack;
  logic             r_wdog;
  logic [HW-1:0]    r_hold_cnt;
  logic [SW-1:0]    r_starve;

  logic             w_cr_vld;
  logic             w_hd_vld;
  logic             w_starve_ok;
  logic             w_cr_win;
  logic             w_hd_win;
  logic             w_own_done;
  logic             w_wdog;
  logic [HW-1:0]    w_hold_nxt;

  // Arbitration and release decisions for the coming edge
  always_comb begin
    w_cr_vld    = i_cr_req && (32'(i_cr_qid) < NUM_Q) && i_pd_ptr_rdy[i_cr_qid];
    w_hd_vld    = i_hd_req && (32'(i_hd_qid) < NUM_Q) && i_pd_ptr_rdy[i_hd_qid];
    w_starve_ok = (r_starve < SW'(STARVE_MAX));
    // HD is preferred until CR has lost STARVE_MAX contested arbitrations in a row
    w_hd_win    = (r_state == ST_IDLE) && w_hd_vld && (!w_cr_vld || w_starve_ok);
    w_cr_win    = (r_state == ST_IDLE) && w_cr_vld && !w_hd_win;
    // Count including the current OWN cycle; release once the owner has had HOLD_MAX cycles
    w_hold_nxt  = r_hold_cnt + HW'(1);
    w_own_done  = ((r_state == ST_OWN_CR) && i_cr_done) ||
                  ((r_state == ST_OWN_HD) && i_hd_done);
    w_wdog      = (r_state != ST_IDLE) && !w_own_done && (w_hold_nxt == HW'(HOLD_MAX));
  end

  // Ownership FSM with registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cr_gnt   <= 1'b0;
      r_cr_own   <= 1'b0;
      r_hd_gnt   <= 1'b0;
      r_hd_own   <= 1'b0;
      r_ack      <= '0;
      r_wdog     <= 1'b0;
      r_hold_cnt <= '0;
      r_starve   <= '0;
    end else begin
      r_cr_gnt <= 1'b0;
      r_hd_gnt <= 1'b0;
      r_ack    <= '0;
      r_wdog   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_hold_cnt <= '0;
          if (w_hd_win) begin
            r_state  <= ST_OWN_HD;
            r_hd_gnt <= 1'b1;
            r_hd_own <= 1'b1;
            r_ack    <= NUM_Q'(1) << i_hd_qid;
            if (w_cr_vld && w_starve_ok) begin
              r_starve <= r_starve + SW'(1);
            end
          end else if (w_cr_win) begin
            r_state  <= ST_OWN_CR;
            r_cr_gnt <= 1'b1;
            r_cr_own <= 1'b1;
            r_ack    <= NUM_Q'(1) << i_cr_qid;
            r_starve <= '0;
          end
        end
        ST_OWN_CR, ST_OWN_HD: begin
          r_hold_cnt <= w_hold_nxt;
          // done in the watchdog cycle wins, so w_wdog is already masked by w_own_done
          if (w_own_done || w_wdog) begin
            r_state  <= ST_IDLE;
            r_cr_own <= 1'b0;
            r_hd_own <= 1'b0;
            r_wdog   <= w_wdog;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cr_own <= 1'b0;
          r_hd_own <= 1'b0;
        end
      endcase
    end
  end

`ifdef PD_ARB_STATS_EN
  logic [31:0] r_cr_gnt_cnt;
  logic [31:0] r_hd_gnt_cnt;
  logic [15:0] r_wdog_cnt;

  // Free-running event counters, wrapping modulo their width
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cr_gnt_cnt <= '0;
      r_hd_gnt_cnt <= '0;
      r_wdog_cnt   <= '0;
    end else begin
      if (w_cr_win) r_cr_gnt_cnt <= r_cr_gnt_cnt + 32'd1;
      if (w_hd_win) r_hd_gnt_cnt <= r_hd_gnt_cnt + 32'd1;
      if (w_wdog)   r_wdog_cnt   <= r_wdog_cnt + 16'd1;
    end
  end

  assign o_cr_gnt_cnt = r_cr_gnt_cnt;
  assign o_hd_gnt_cnt = r_hd_gnt_cnt;
  assign o_wdog_cnt   = r_wdog_cnt;
`endif

  assign o_cr_gnt     = r_cr_gnt;
  assign o_cr_own     = r_cr_own;
  assign o_hd_gnt     = r_hd_gnt;
  assign o_hd_own     = r_hd_own;
  assign o_pd_ptr_ack = r_ack;
  assign o_wdog_err   = r_wdog;

endmodule
